// File: rtl/shift_pipe.sv
// ----------------------------------------------------------------------------
// shift_pipe
//   Two-stage pipelined barrel shifter with valid/ready handshakes on both
//   sides. It supports logical, arithmetic and rotate modes, and produces
//   carry-out and zero flags.
//   Stage 1 captures the request and applies the coarse shift, which is the
//   amount with its low LO bits cleared. Stage 2 applies the remaining low
//   LO bits, computes the flags and holds the registered outputs.
//
// Parameters
//   WIDTH  operand/result width (power of two, >= 4)
//   AW     shift-amount width, $clog2(WIDTH); derived, do not override
//   LO     number of low amount bits applied in stage 2, AW/2
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous active-low reset
//   in_valid      request valid
//   in_ready      request accepted this cycle (combinational on out_ready)
//   operand       value to shift
//   direction     1 = left, 0 = right
//   mode          00 logical, 01 arithmetic, 10 rotate, 11 same as 00
//   shift_amount  shift distance 0..WIDTH-1
//   out_valid     result valid
//   out_ready     consumer accepts result
//   result        shifted value
//   carry_out     last bit shifted/rotated out
//   zero          result == 0
//
// Build option
//   SHIFT_PIPE_CARRY_EN  when defined, carry_out is computed and registered,
//                        and stage 1 also keeps the original operand and the
//                        full amount. When undefined, carry_out is 0 and that
//                        storage does not exist.
// ----------------------------------------------------------------------------
module shift_pipe #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH),
  parameter int LO    = AW / 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             direction,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    shift_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero
);

  // Shifts val by amt in the requested direction and mode.
  // Mode 11 has already been folded to 00 by the caller.
  function automatic logic [WIDTH-1:0] shift_f(
    input logic [WIDTH-1:0] val,
    input logic             left,
    input logic [1:0]       md,
    input logic [AW-1:0]    amt
  );
    logic signed [WIDTH-1:0] sval;
    logic [WIDTH-1:0]        res;
    sval = val;
    if (md == 2'b10) begin
      // A shift by the full WIDTH yields 0, so amt == 0 leaves val unchanged.
      if (left) res = (val << amt) | (val >> (WIDTH - int'(amt)));
      else      res = (val >> amt) | (val << (WIDTH - int'(amt)));
    end else if (left) begin
      res = val << amt;
    end else if (md == 2'b01) begin
      res = sval >>> amt;
    end else begin
      res = val >> amt;
    end
    return res;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_val_q,   s1_val_d;
  logic             s1_left_q,  s1_left_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  logic [LO-1:0]    s1_fine_q,  s1_fine_d;

  logic             s2_valid_q,  s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic             s2_zero_q,   s2_zero_d;

  logic             s1_ready, s2_ready;
  logic             accept, advance;
  logic [1:0]       mode_norm;
  logic [AW-1:0]    coarse_amt;
  logic [WIDTH-1:0] fine_res;

  assign s2_ready = !s2_valid_q || out_ready;
  assign s1_ready = !s1_valid_q || s2_ready;
  assign in_ready = s1_ready;
  assign accept   = in_valid && s1_ready;
  assign advance  = s1_valid_q && s2_ready;

  assign mode_norm  = (mode == 2'b11) ? 2'b00 : mode;
  assign coarse_amt = {shift_amount[AW-1:LO], {LO{1'b0}}};
  assign fine_res   = shift_f(s1_val_q, s1_left_q, s1_mode_q, AW'(s1_fine_q));

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_val_d    = s1_val_q;
    s1_left_d   = s1_left_q;
    s1_mode_d   = s1_mode_q;
    s1_fine_d   = s1_fine_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_zero_d   = s2_zero_q;

    if (s1_ready) s1_valid_d = in_valid;
    if (accept) begin
      s1_val_d  = shift_f(operand, direction, mode_norm, coarse_amt);
      s1_left_d = direction;
      s1_mode_d = mode_norm;
      s1_fine_d = shift_amount[LO-1:0];
    end

    if (s2_ready) s2_valid_d = s1_valid_q;
    if (advance) begin
      s2_result_d = fine_res;
      s2_zero_d   = (fine_res == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_val_q    <= '0;
      s1_left_q   <= 1'b0;
      s1_mode_q   <= 2'b00;
      s1_fine_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_val_q    <= s1_val_d;
      s1_left_q   <= s1_left_d;
      s1_mode_q   <= s1_mode_d;
      s1_fine_q   <= s1_fine_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_zero_q   <= s2_zero_d;
    end
  end

`ifdef SHIFT_PIPE_CARRY_EN
  logic [WIDTH-1:0] s1_op_q,  s1_op_d;
  logic [AW-1:0]    s1_amt_q, s1_amt_d;
  logic             carry_q,  carry_d;
  logic [AW-1:0]    idx_r, idx_l;
  logic             carry_calc;

  // Right shifts lose operand[amt-1] last. Left shifts lose
  // operand[WIDTH-amt] last; that index is -amt modulo WIDTH.
  assign idx_r      = s1_amt_q - AW'(1);
  assign idx_l      = AW'(0) - s1_amt_q;
  assign carry_calc = (s1_amt_q == '0) ? 1'b0
                    : (s1_left_q ? s1_op_q[idx_l] : s1_op_q[idx_r]);

  always_comb begin
    s1_op_d  = s1_op_q;
    s1_amt_d = s1_amt_q;
    carry_d  = carry_q;
    if (accept) begin
      s1_op_d  = operand;
      s1_amt_d = shift_amount;
    end
    if (advance) carry_d = carry_calc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_op_q  <= '0;
      s1_amt_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      s1_op_q  <= s1_op_d;
      s1_amt_q <= s1_amt_d;
      carry_q  <= carry_d;
    end
  end

  assign carry_out = carry_q;
`else
  assign carry_out = 1'b0;
`endif

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign zero      = s2_zero_q;

endmodule
